fifo_uart_tx: RTL
=================

# fifo_uart_tx

Byte-serial UART transmitter that drains the 8-bit synchronous FIFO directly downstream of it. Whenever the FIFO is non-empty and the transmitter is idle, it pops one byte and shifts it out as 8N1: one start bit, 8 data bits LSB first, one stop bit. It is the consumer stage of the FIFO and turns buffered bytes into a serial line.

## Interface
Parameters:
- CLKS_PER_BIT, default 4: clock cycles per serial bit. Legal range is 2..65535; values outside it are a configuration error.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  8  FIFO data_out; valid on the cycle after fifo_rd_en is sampled high.
- fifo_rd_en  out  1  one-cycle pop request to the FIFO.
- tx  out  1  serial line; idles high.
- busy  out  1  high from the pop cycle through the last cycle of the stop bit.

## Operation
- States: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE: tx=1, busy=0, fifo_rd_en=0.
  - If fifo_empty=0, go to POP.
  - Otherwise stay in IDLE.
- POP: fifo_rd_en=1 for exactly this one cycle, busy=1, go to LOAD.
- LOAD: capture fifo_data into an 8-bit shift register, clear the bit-timer, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx = shift_reg[0] for CLKS_PER_BIT cycles per bit, then shift right and increment the bit index.
  - After bit index 7 completes, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - At the end, if fifo_empty=0, go directly to POP (back-to-back frames).
  - Otherwise go to IDLE.
- Bit timer: counter of width $clog2(CLKS_PER_BIT) that counts 0..CLKS_PER_BIT-1 and wraps. Bit index: 3-bit counter.
- fifo_rd_en is never asserted while fifo_empty=1. It is asserted at most once per frame.
- fifo_empty is sampled only in IDLE and in the last STOP cycle. Changes at other times are ignored.
- tx is driven from a register, so it carries no combinational glitches.

## Timing
- Reset values: tx=1, fifo_rd_en=0, busy=0, state=IDLE, counters=0, shift register=0.
- Reset is asynchronous: asserting rst mid-frame forces all outputs to reset values immediately.
  - The partially sent byte is lost.
  - No extra pop occurs.
- Let T0 be the first rising edge in IDLE that sees fifo_empty=0:
  - POP is the cycle after T0. fifo_rd_en is high during that cycle.
  - LOAD is one cycle after POP.
  - The start bit begins one cycle after LOAD and lasts CLKS_PER_BIT cycles.
  - Data bit k occupies cycles [(k+1)·CLKS_PER_BIT, (k+2)·CLKS_PER_BIT) measured from the start-bit edge.
  - The stop bit ends 10·CLKS_PER_BIT cycles after the start-bit edge.
- Frame period, back-to-back: 10·CLKS_PER_BIT + 2 cycles. The 2 overhead cycles are POP and LOAD, with tx held high.
- FIFO read latency is fixed at 1 cycle: data is captured in the cycle after fifo_rd_en.
- A simultaneous FIFO write during POP does not affect the popped byte.
- Empty boundary: if the FIFO becomes empty during a frame, the frame completes, then the block returns to IDLE.
- Full boundary: the block has no backpressure input. The FIFO's full flag is the upstream producer's concern.

## Test plan
- Reset: hold rst=1 for 3 cycles with fifo_empty=0 -> tx=1, fifo_rd_en=0, busy=0 throughout; no pop.
- Single byte 0xA5, CLKS_PER_BIT=4 -> exactly one fifo_rd_en pulse; tx sequence by 4-cycle slots is 0, 1,0,1,0,0,1,0,1, 1; busy falls after 40 bit-cycles plus 2.
- Back-to-back 0x00 then 0xFF -> two pops spaced 42 cycles apart.
  - First frame: tx low for 36 cycles, then high.
  - Second frame: start bit low for 4 cycles, then high for 36 cycles.
  - tx is high during POP/LOAD between the frames.
- Empty FIFO: fifo_empty=1 for 100 cycles -> fifo_rd_en never asserts, tx=1, busy=0.
- Reset mid-frame: assert rst during data bit 3 of 0x3C, release, keep fifo_empty=1 -> tx=1 immediately; no further rd_en.
- CLKS_PER_BIT=2, bytes 0x01, 0x80, 0x55 -> three frames of 22 cycles each; decoded serial bytes match in order.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: 8N1 UART transmitter that drains an 8-bit synchronous FIFO.
// While the FIFO is non-empty and the line is idle it pops one byte and shifts
// it out as start bit, 8 data bits LSB first, then stop bit, with each bit held
// for CLKS_PER_BIT clocks. Consecutive frames run back-to-back when more data
// is waiting at the end of a stop bit.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit, legal range 2..65535
// Ports:
//   clk         in   single rising-edge clock
//   rst         in   asynchronous active-high reset
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  out  one-cycle pop request
//   tx          out  registered serial line, idles high
//   busy        out  high from the pop cycle through the last stop-bit cycle
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          r_state, w_state_next;
  logic [TW-1:0]   r_timer, w_timer_next;
  logic [2:0]      r_idx,   w_idx_next;
  logic [7:0]      r_shift, w_shift_next;
  logic            r_tx,    w_tx_next;
  logic            w_bit_done;
  logic [TW-1:0]   w_timer_inc;

  assign w_bit_done  = (r_timer == LAST);
  assign w_timer_inc = w_bit_done ? '0 : r_timer + TW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  // The line level is computed for the upcoming state so the registered tx
  // changes on the same edge as the state it belongs to.
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (!fifo_empty) begin
          w_state_next = S_POP;
        end
      end
      S_POP: begin
        w_tx_next    = 1'b1;
        w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_shift_next = fifo_data;
        w_timer_next = '0;
        w_idx_next   = '0;
        w_tx_next    = 1'b0;
        w_state_next = S_START;
      end
      S_START: begin
        w_timer_next = w_timer_inc;
        w_tx_next    = 1'b0;
        if (w_bit_done) begin
          w_idx_next   = '0;
          w_tx_next    = r_shift[0];
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        w_timer_next = w_timer_inc;
        if (w_bit_done) begin
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_idx == 3'd7) begin
            w_tx_next    = 1'b1;
            w_state_next = S_STOP;
          end else begin
            w_idx_next = r_idx + 3'd1;
            w_tx_next  = r_shift[1];
          end
        end
      end
      S_STOP: begin
        w_timer_next = w_timer_inc;
        w_tx_next    = 1'b1;
        if (w_bit_done) begin
          w_state_next = fifo_empty ? S_IDLE : S_POP;
        end
      end
      default: begin
        w_tx_next    = 1'b1;
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign fifo_rd_en = (r_state == S_POP);
  assign busy       = (r_state != S_IDLE);
  assign tx         = r_tx;

endmodule
